// File: rtl/cpu_pkg.sv
// Shared definitions for the program sequencer: FSM state encoding, the halt opcode
// and the field positions of a 16-bit program word.
package cpu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_DONE,
    S_ERROR
  } seq_state_t;

  localparam logic [3:0] HALT_OP = 4'hF;

  localparam int unsigned OPC_MSB   = 15;
  localparam int unsigned OPC_LSB   = 12;
  localparam int unsigned INSTR_MSB = 11;

endpackage

// File: rtl/instr_sequencer_prog_mem.sv
// Program buffer for the sequencer: DEPTH x 16 register array with a synchronous
// write port and an asynchronous read port.
module prog_mem #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [15:0]   i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [15:0]   o_rdata
);

  logic [15:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/instr_sequencer.sv
// Program sequencer: fetches words from prog_mem, issues them to the core and waits
// for exec_done. Define INSTR_SEQUENCER_STEP_EN for single-step operation (step_pulse).
module instr_sequencer #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned AW      = 4,
  parameter int unsigned TIMEOUT = 64,
  parameter logic [3:0]  HALT_OP = cpu_pkg::HALT_OP
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [15:0]   prog_data,
  input  logic          run_start,
  input  logic          halt_req,
  input  logic          exec_done,
`ifdef INSTR_SEQUENCER_STEP_EN
  input  logic          step_pulse,
`endif
  output logic [3:0]    opcode,
  output logic [11:0]   instr,
  output logic          inst_done,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          halted,
  output logic          timeout_err
);

  import cpu_pkg::*;

  localparam int unsigned   CW   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  localparam logic [CW-1:0] TLIM = CW'(TIMEOUT - 1);

  seq_state_t    r_state, w_next;
  logic [AW-1:0] r_pc, w_pc_next;
  logic [15:0]   r_ir, w_ir_next;
  logic [CW-1:0] r_cnt, w_cnt_next;
  logic [15:0]   w_rd;
  logic          w_mem_we;
  logic          w_step;

  assign w_mem_we = prog_we && (r_state == S_IDLE || r_state == S_DONE || r_state == S_ERROR);

`ifdef INSTR_SEQUENCER_STEP_EN
  assign w_step = step_pulse;
`else
  assign w_step = 1'b1;
`endif

  prog_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_prog_mem (
    .i_clk   (clk),
    .i_we    (w_mem_we),
    .i_waddr (prog_addr),
    .i_wdata (prog_data),
    .i_raddr (r_pc),
    .o_rdata (w_rd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_ir    <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_pc    <= w_pc_next;
      r_ir    <= w_ir_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_pc_next  = r_pc;
    w_ir_next  = r_ir;
    w_cnt_next = r_cnt;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (run_start) begin
          w_next     = S_FETCH;
          w_pc_next  = '0;
          w_cnt_next = '0;
        end
      end
      S_FETCH: begin
        // Timeout budget restarts for every instruction, not just per run.
        w_ir_next  = w_rd;
        w_cnt_next = '0;
        if (w_rd[OPC_MSB:OPC_LSB] == HALT_OP || halt_req) begin
          w_next = S_DONE;
        end else if (w_step) begin
          w_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_next = S_WAIT;
      end
      S_WAIT: begin
        if (exec_done) begin
          if (r_pc == LAST || halt_req) begin
            w_next = S_DONE;
          end else begin
            w_pc_next = r_pc + AW'(1);
            w_next    = S_FETCH;
          end
        end else if (r_cnt == TLIM) begin
          w_next = S_ERROR;
        end else begin
          w_cnt_next = r_cnt + CW'(1);
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  assign opcode      = r_ir[OPC_MSB:OPC_LSB];
  assign instr       = r_ir[INSTR_MSB:0];
  assign pc          = r_pc;
  assign inst_done   = (r_state == S_ISSUE);
  assign busy        = (r_state == S_FETCH) || (r_state == S_ISSUE) || (r_state == S_WAIT);
  assign halted      = (r_state == S_DONE);
  assign timeout_err = (r_state == S_ERROR);

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed scenarios plus random stimulus,
// all outputs compared every cycle against a run/age behavioural model.
module tb_instr_sequencer;

  localparam int DEPTH   = 16;
  localparam int AW      = 4;
  localparam int TIMEOUT = 64;

  logic          clk = 1'b0;
  logic          rst, prog_we, run_start, halt_req, exec_done;
  logic [AW-1:0] prog_addr;
  logic [15:0]   prog_data;
  logic [3:0]    opcode;
  logic [11:0]   instr;
  logic          inst_done, busy, halted, timeout_err;
  logic [AW-1:0] pc;
`ifdef INSTR_SEQUENCER_STEP_EN
  logic          step_pulse;
`endif

  always #5 clk = ~clk;

  instr_sequencer #(
    .DEPTH   (DEPTH),
    .AW      (AW),
    .TIMEOUT (TIMEOUT),
    .HALT_OP (4'hF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .run_start   (run_start),
    .halt_req    (halt_req),
    .exec_done   (exec_done),
`ifdef INSTR_SEQUENCER_STEP_EN
    .step_pulse  (step_pulse),
`endif
    .opcode      (opcode),
    .instr       (instr),
    .inst_done   (inst_done),
    .pc          (pc),
    .busy        (busy),
    .halted      (halted),
    .timeout_err (timeout_err)
  );

  int n_cmp   = 0;
  int n_bad   = 0;
  int n_issue = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: a run is either stopped (idle/halted/error) or running, and a
  // running instruction is tracked by its age in cycles since its fetch began.
  typedef enum {M_IDLE, M_RUN, M_HALT, M_ERR} mmode_t;
  mmode_t      m_mode  = M_IDLE;
  int          m_age   = 0;
  int          m_pc    = 0;
  logic [15:0] m_ir    = '0;
  bit          m_known = 1'b0;
  logic [15:0] m_mem [DEPTH];

  always @(posedge clk) begin
    bit step_ok;
`ifdef INSTR_SEQUENCER_STEP_EN
    step_ok = step_pulse;
`else
    step_ok = 1'b1;
`endif
    if (m_known && m_mode != M_RUN && prog_we) m_mem[prog_addr] = prog_data;
    if (rst) begin
      m_mode = M_IDLE; m_pc = 0; m_ir = '0; m_age = 0; m_known = 1'b1;
    end else if (m_mode == M_RUN) begin
      if (m_age == 0) begin
        m_ir = m_mem[m_pc];
        if (m_ir[15:12] == 4'hF || halt_req) m_mode = M_HALT;
        else if (step_ok) m_age = 1;
      end else if (m_age == 1) begin
        m_age = 2;
      end else if (exec_done) begin
        if (m_pc == DEPTH - 1 || halt_req) m_mode = M_HALT;
        else begin m_pc = m_pc + 1; m_age = 0; end
      end else if (m_age - 2 == TIMEOUT - 1) begin
        m_mode = M_ERR;
      end else begin
        m_age = m_age + 1;
      end
    end else if (run_start) begin
      m_mode = M_RUN; m_pc = 0; m_age = 0;
    end
  end

  always @(negedge clk) begin
    if (inst_done === 1'b1) n_issue++;
    if (m_known) begin
      chk("inst_done",   32'(inst_done),   32'(m_mode == M_RUN && m_age == 1));
      chk("busy",        32'(busy),        32'(m_mode == M_RUN));
      chk("halted",      32'(halted),      32'(m_mode == M_HALT));
      chk("timeout_err", 32'(timeout_err), 32'(m_mode == M_ERR));
      chk("pc",          32'(pc),          32'(m_pc));
      chk("opcode",      32'(opcode),      32'(m_ir[15:12]));
      chk("instr",       32'(instr),       32'(m_ir[11:0]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int a, input logic [15:0] d);
    prog_we = 1'b1; prog_addr = AW'(a); prog_data = d;
    tick();
    prog_we = 1'b0;
  endtask

  task automatic start();
    run_start = 1'b1;
    tick();
    run_start = 1'b0;
  endtask

  task automatic wait_issue(input string nm);
    int k = 0;
    while (inst_done !== 1'b1 && k < 40) begin tick(); k++; end
    chk({nm, "_issue_seen"}, 32'(inst_done), 32'd1);
  endtask

  task automatic serve(input int dly, input int budget);
    int k = 0;
    while (k < budget) begin
      if (inst_done === 1'b1) begin
        repeat (dly) tick();
        exec_done = 1'b1; tick(); exec_done = 1'b0;
        k += dly + 1;
      end else if (busy !== 1'b1) begin
        break;
      end else begin
        tick(); k++;
      end
    end
    chk("serve_in_budget", 32'(k < budget), 32'd1);
  endtask

  task automatic stop_after_current();
    halt_req = 1'b1; exec_done = 1'b1;
    tick();
    halt_req = 1'b0; exec_done = 1'b0;
  endtask

  initial begin
    int base, ed_rate;
    rst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    run_start = 1'b0; halt_req = 1'b0; exec_done = 1'b0;
`ifdef INSTR_SEQUENCER_STEP_EN
    step_pulse = 1'b1;
`endif
    tick(); tick();
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_opcode", 32'(opcode), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;

    // Scenario 1: issue latency, single instruction then halt word.
    load(0, 16'h8123); load(1, 16'hF000);
    base = n_issue;
    start();
    chk("s1_t1_inst_done", 32'(inst_done), 32'd0);
    chk("s1_t1_busy", 32'(busy), 32'd1);
    tick();
    chk("s1_t2_inst_done", 32'(inst_done), 32'd1);
    chk("s1_opcode", 32'(opcode), 32'h8);
    chk("s1_instr", 32'(instr), 32'h123);
    repeat (9) tick();
    exec_done = 1'b1; tick(); exec_done = 1'b0;
    chk("s1_pc_adv", 32'(pc), 32'd1);
    tick();
    chk("s1_halted", 32'(halted), 32'd1);
    chk("s1_opcode_halt", 32'(opcode), 32'hF);
    tick();
    chk("s1_issue_count", 32'(n_issue - base), 32'd1);

    // Scenario 2: full buffer, no wrap past the last word.
    for (int i = 0; i < DEPTH; i++) load(i, {4'h1, 12'(i * 3)});
    base = n_issue;
    start();
    serve(3, 400);
    tick();
    chk("s2_issue_count", 32'(n_issue - base), 32'd16);
    chk("s2_pc", 32'(pc), 32'd15);
    chk("s2_halted", 32'(halted), 32'd1);

    // Scenario 3: timeout trap and recovery.
    load(0, 16'h2ABC);
    start(); tick(); tick();
    repeat (63) tick();
    chk("s3_still_wait", 32'(busy), 32'd1);
    chk("s3_no_err_yet", 32'(timeout_err), 32'd0);
    tick();
    chk("s3_timeout_err", 32'(timeout_err), 32'd1);
    chk("s3_pc", 32'(pc), 32'd0);
    start();
    chk("s3_err_cleared", 32'(timeout_err), 32'd0);
    tick();
    chk("s3_reissue", 32'(inst_done), 32'd1);
    chk("s3_reissue_op", 32'(opcode), 32'h2);
    chk("s3_reissue_instr", 32'(instr), 32'hABC);
    tick();
    stop_after_current();
    chk("s3_halted", 32'(halted), 32'd1);

    // Scenario 4: halt_req during WAIT of instruction 2.
    for (int i = 0; i < 5; i++) load(i, {4'h3, 12'(i)});
    base = n_issue;
    start();
    for (int n = 0; n < 2; n++) begin
      wait_issue("s4");
      tick(); exec_done = 1'b1; tick(); exec_done = 1'b0;
    end
    wait_issue("s4_i2");
    tick(); halt_req = 1'b1; tick(); tick();
    exec_done = 1'b1; tick(); exec_done = 1'b0; halt_req = 1'b0;
    chk("s4_halted", 32'(halted), 32'd1);
    chk("s4_pc", 32'(pc), 32'd2);
    repeat (4) tick();
    chk("s4_issue_count", 32'(n_issue - base), 32'd3);

    // Scenario 5: reset in WAIT together with exec_done; write while busy ignored.
    start();
    wait_issue("s5");
    tick();
    prog_we = 1'b1; prog_addr = '0; prog_data = 16'h7777;
    exec_done = 1'b1; rst = 1'b1;
    tick();
    prog_we = 1'b0; exec_done = 1'b0; rst = 1'b0;
    chk("s5_busy", 32'(busy), 32'd0);
    chk("s5_pc", 32'(pc), 32'd0);
    chk("s5_opcode", 32'(opcode), 32'd0);
    chk("s5_instr", 32'(instr), 32'd0);
    chk("s5_flags", 32'({inst_done, halted, timeout_err}), 32'd0);
    start();
    wait_issue("s5_rerun");
    chk("s5_mem_kept", 32'({opcode, instr}), 32'h3000);
    tick();
    stop_after_current();

`ifdef INSTR_SEQUENCER_STEP_EN
    // Scenario 6: single step holds FETCH until step_pulse.
    step_pulse = 1'b0;
    base = n_issue;
    start();
    repeat (5) tick();
    chk("s6_held_busy", 32'(busy), 32'd1);
    chk("s6_held_no_issue", 32'(n_issue - base), 32'd0);
    step_pulse = 1'b1;
    tick();
    step_pulse = 1'b0;
    chk("s6_step_issue", 32'(inst_done), 32'd1);
    tick();
    stop_after_current();
    step_pulse = 1'b1;
`endif

    // Random phase: everything checked cycle by cycle against the model.
    ed_rate = 3;
    for (int c = 0; c < 4000; c++) begin
      if (c % 500 == 0) ed_rate = (c % 1000 == 0) ? 3 : 90;
      exec_done = ($urandom_range(0, ed_rate) == 0);
      halt_req  = ($urandom_range(0, 40) == 0);
      run_start = (busy !== 1'b1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 60) == 0);
      prog_we   = ($urandom_range(0, 5) == 0);
      prog_addr = AW'($urandom);
      prog_data = {($urandom_range(0, 15) == 0) ? 4'hF : 4'($urandom_range(0, 14)), 12'($urandom)};
      rst       = ($urandom_range(0, 400) == 0);
`ifdef INSTR_SEQUENCER_STEP_EN
      step_pulse = ($urandom_range(0, 2) == 0);
`endif
      tick();
    end
    exec_done = 1'b0; halt_req = 1'b0; run_start = 1'b0; prog_we = 1'b0; rst = 1'b0;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
